// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO drain reader: FSM state encoding and the
// width rule for burst-length / remaining-count signals.
package lifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    // Counter width able to hold 0..size inclusive.
    function automatic int cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register for the drained word stream. A load always
// wins; an accepted word with no new load empties the register. While the
// consumer stalls, nothing here changes.
module stream_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    // Hold, load or drain the output word; data is kept after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/lifo_drain_reader.sv
// Pops a burst of words from an attached LIFO and forwards them on a
// valid/ready stream, most recently pushed word first.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start with a non-zero length
//   ST_DRAIN | popping words while the LIFO has data and the output has room
//   ST_FLUSH | last word popped, waiting for the consumer to take it
//
// remaining is a down-counter; the pop that sees it at 1 is the last one.
// An empty LIFO simply stalls the burst for as long as it takes.
module lifo_drain_reader
    import lifo_pkg::*;
#(
    parameter int  LIFO_SIZE = 8,
    parameter int  DATA_W    = 8,
    localparam int CNT_W     = cnt_w(LIFO_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lifo_val,
    input  logic              lifo_full,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              lifo_read,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  remaining
);

    localparam logic [CNT_W-1:0] LIFO_CNT = CNT_W'(LIFO_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    drain_state_t     state;
    drain_state_t     state_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic             done_nxt;
    logic             pop;
    logic             pop_last;

    // Full flag is informational; draining is governed by lifo_val alone.
    logic lifo_full_unused;
    assign lifo_full_unused = lifo_full;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pop decision, counter update and completion pulse.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        pop_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                // done high means a burst just ended; a start now is dropped.
                if (start && (len != '0) && !done) begin
                    state_nxt = ST_DRAIN;
                    rem_nxt   = (len > LIFO_CNT) ? LIFO_CNT : len;
                end
            end
            ST_DRAIN: begin
                if (lifo_val && (remaining != '0) && (!m_valid || m_ready)) begin
                    pop      = 1'b1;
                    pop_last = (remaining == CNT_ONE);
                    rem_nxt  = remaining - CNT_ONE;
                    if (pop_last) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (m_valid && m_ready && m_last) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst down-counter and registered done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            remaining <= rem_nxt;
            done      <= done_nxt;
        end
    end

    assign lifo_read = pop;
    assign busy      = (state != ST_IDLE);

    stream_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (pop),
        .load_data (lifo_data),
        .load_last (pop_last),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule

// File: tb/tb_lifo_drain_reader.sv
// Bench for lifo_drain_reader: an 8x8 stack model attached to the LIFO port,
// a stream monitor, directed burst sequences, a table of burst lengths and
// randomized bursts checked against a stack-order reference.
module tb_lifo_drain_reader;

    localparam int LIFO_SIZE = 8;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;

    logic              clk;
    logic              reset;
    logic              lifo_val;
    logic              lifo_full;
    logic [DATA_W-1:0] lifo_data;
    logic              lifo_read;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  remaining;

    int checks = 0;
    int errors = 0;

    lifo_drain_reader #(
        .LIFO_SIZE (LIFO_SIZE),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lifo_val  (lifo_val),
        .lifo_full (lifo_full),
        .lifo_data (lifo_data),
        .lifo_read (lifo_read),
        .start     (start),
        .len       (len),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model and stream monitor state
    logic [7:0] stk [8];
    int         depth = 0;
    bit         push_req = 1'b0;
    logic [7:0] push_data = 8'h00;
    bit         clr_req = 1'b0;
    int         pops = 0;
    int         done_cnt = 0;
    logic [8:0] rx_q [$];
    bit         hold_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    assign lifo_val  = (depth > 0);
    assign lifo_full = (depth == LIFO_SIZE);

    always_comb begin
        lifo_data = 8'h00;
        if (depth > 0) lifo_data = stk[3'(depth - 1)];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (lifo_read) begin
            checks++;
            if (depth == 0) begin
                errors++;
                $display("FAIL rd_empty: lifo_read=1 with depth 0 at %0t", $time);
            end
        end
        if (hold_prev && !reset) begin
            checks++;
            if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
                errors++;
                $display("FAIL stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                         m_valid, m_data, m_last, prev_data, prev_last);
            end
        end
        hold_prev <= m_valid && !m_ready && !reset;
        prev_data <= m_data;
        prev_last <= m_last;
        if (clr_req) begin
            depth    <= 0;
            pops     <= 0;
            done_cnt <= 0;
            rx_q.delete();
        end else begin
            if (lifo_read) pops <= pops + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
            if (lifo_read && depth > 0 && push_req) begin
                stk[3'(depth - 1)] <= push_data;
            end else if (lifo_read && depth > 0) begin
                depth <= depth - 1;
            end else if (push_req && depth < LIFO_SIZE) begin
                stk[3'(depth)] <= push_data;
                depth <= depth + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_one(input logic [7:0] v);
        push_req  = 1'b1;
        push_data = v;
        step();
        push_req  = 1'b0;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push_one(8'(base + i));
    endtask

    task automatic clear_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = CNT_W'(l);
        step();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0) break;
            step();
        end
        chk(nm, done_cnt, 1);
    endtask

    task automatic wait_rx(input int n, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            step();
        end
        chk(nm, rx_q.size(), n);
    endtask

    typedef struct {
        int fill;
        int blen;
        bit exp_busy;
        int exp_pops;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   d, l, n, got, pend;
        bit   seen;
        logic [7:0] words [8];
        logic [7:0] exp_q [$];

        vecs[0] = '{3, 3, 1'b1, 3};
        vecs[1] = '{8, 12, 1'b1, 8};
        vecs[2] = '{8, 8, 1'b1, 8};
        vecs[3] = '{5, 1, 1'b1, 1};
        vecs[4] = '{4, 0, 1'b0, 0};
        vecs[5] = '{8, 15, 1'b1, 8};
        vecs[6] = '{7, 2, 1'b1, 2};

        reset   = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_read", lifo_read, 0);
        step();
        reset = 1'b0;
        clear_all();

        // Basic drain, cycle by cycle
        fill(3, 8'h11);
        clear_all();
        push_one(8'h11); push_one(8'h22); push_one(8'h33);
        m_ready = 1'b1;
        start = 1'b1; len = 4'd3;
        smp();
        chk("b_busy0", busy, 0);
        step();
        start = 1'b0;
        smp();
        chk("b_busy1", busy, 1);
        chk("b_read1", lifo_read, 1);
        chk("b_rem3", remaining, 3);
        step(); smp();
        chk("b_w0", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h33});
        chk("b_rem2", remaining, 2);
        step(); smp();
        chk("b_w1", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h22});
        step(); smp();
        chk("b_w2", {m_valid, m_last, m_data}, {1'b1, 1'b1, 8'h11});
        chk("b_rem0", remaining, 0);
        chk("b_read_end", lifo_read, 0);
        step(); smp();
        chk("b_done", {done, busy, m_valid}, {1'b1, 1'b0, 1'b0});
        step(); smp();
        chk("b_done_clr", done, 0);
        chk("b_rx", rx_q.size(), 3);

        // Backpressure after first word
        clear_all();
        push_one(8'h11); push_one(8'h22); push_one(8'h33);
        m_ready = 1'b1;
        start_burst(3);
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk($sformatf("bp_hold%0d", i), {m_valid, m_data, lifo_read}, {1'b1, 8'h33, 1'b0});
            step();
        end
        m_ready = 1'b1;
        wait_done(30, "bp_done");
        chk("bp_pops", pops, 3);
        chk("bp_n", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("bp_o0", rx_q[0], {1'b0, 8'h33});
            chk("bp_o1", rx_q[1], {1'b0, 8'h22});
            chk("bp_o2", rx_q[2], {1'b1, 8'h11});
        end

        // Underflow stall and resume on late pushes
        clear_all();
        push_one(8'hAA); push_one(8'hBB);
        m_ready = 1'b1;
        start_burst(4);
        wait_rx(2, 20, "uf_two");
        step(); step();
        smp();
        chk("uf_stall", {busy, lifo_read, m_valid, remaining}, {1'b1, 1'b0, 1'b0, 4'd2});
        step();
        push_one(8'hA5);
        wait_rx(3, 20, "uf_three");
        smp();
        chk("uf_rem1", remaining, 1);
        if (rx_q.size() >= 3) chk("uf_a5", rx_q[2], {1'b0, 8'hA5});
        step();
        push_one(8'h5A);
        wait_done(20, "uf_done");
        if (rx_q.size() >= 4) chk("uf_5a", rx_q[3], {1'b1, 8'h5A});
        chk("uf_pops", pops, 4);

        // Table of lengths against a prefilled stack
        foreach (vecs[k]) begin
            clear_all();
            fill(vecs[k].fill, 8'h80);
            m_ready = 1'b1;
            start_burst(vecs[k].blen);
            smp();
            chk($sformatf("t%0d_busy", k), busy, vecs[k].exp_busy);
            step();
            if (vecs[k].exp_pops > 0) begin
                wait_done(60, $sformatf("t%0d_done", k));
                chk($sformatf("t%0d_n", k), rx_q.size(), vecs[k].exp_pops);
                if (rx_q.size() > 0)
                    chk($sformatf("t%0d_last", k), rx_q[rx_q.size() - 1],
                        {1'b1, 8'(8'h80 + vecs[k].fill - vecs[k].exp_pops)});
            end else begin
                repeat (4) step();
                chk($sformatf("t%0d_nodone", k), done_cnt, 0);
            end
            chk($sformatf("t%0d_pops", k), pops, vecs[k].exp_pops);
            chk($sformatf("t%0d_depth", k), depth, vecs[k].fill - vecs[k].exp_pops);
        end

        // start while busy is ignored
        clear_all();
        fill(6, 8'h40);
        m_ready = 1'b0;
        start_burst(2);
        step();
        start = 1'b1; len = 4'd4;
        step();
        start = 1'b0;
        m_ready = 1'b1;
        wait_done(30, "sb_done");
        chk("sb_pops", pops, 2);
        chk("sb_depth", depth, 4);

        // start coinciding with done is ignored
        start_burst(1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("sd_seen", seen, 1);
        start = 1'b1; len = 4'd1;
        step();
        start = 1'b0;
        smp();
        chk("sd_idle", {busy, lifo_read}, 2'b00);
        step(); step();
        chk("sd_pops", pops, 3);

        // Reset in the middle of a burst
        clear_all();
        fill(5, 8'h50);
        m_ready = 1'b1;
        start_burst(5);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (pops >= 2) begin
                got = 1;
                break;
            end
        end
        chk("rm_reach", got, 1);
        reset = 1'b1;
        #1;
        chk("rm_out", {lifo_read, m_valid, m_last, m_data, busy, done, remaining}, 0);
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        chk("rm_pops", pops, 2);
        chk("rm_depth", depth, 3);
        chk("rm_busy", busy, 0);

        // Randomized bursts against the stack-order reference
        for (int it = 0; it < 40; it++) begin
            clear_all();
            m_ready = 1'b0;
            d = $urandom_range(0, 8);
            exp_q.delete();
            for (int i = 0; i < d; i++) begin
                words[i] = 8'($urandom);
                push_one(words[i]);
            end
            l = $urandom_range(0, 15);
            n = (l > LIFO_SIZE) ? LIFO_SIZE : l;
            for (int k = 0; k < n && k < d; k++) exp_q.push_back(words[d - 1 - k]);
            pend = (n > d) ? n - d : 0;
            start_burst(l);
            if (n == 0) begin
                step(); step();
                chk($sformatf("r%0d_idle", it), {busy, 8'(pops), 8'(done_cnt)}, 0);
                continue;
            end
            for (int c = 0; c < 600 && done_cnt == 0; c++) begin
                m_ready  = 1'($urandom);
                push_req = 1'b0;
                if (depth == 0 && pend > 0 && $urandom_range(0, 1) == 1) begin
                    push_data = 8'($urandom);
                    push_req  = 1'b1;
                    exp_q.push_back(push_data);
                    pend--;
                end
                step();
            end
            push_req = 1'b0;
            chk($sformatf("r%0d_done", it), done_cnt, 1);
            chk($sformatf("r%0d_n", it), rx_q.size(), n);
            for (int k = 0; k < n && k < rx_q.size(); k++)
                chk($sformatf("r%0d_w%0d", it, k), rx_q[k], {1'(k == n - 1), exp_q[k]});
            chk($sformatf("r%0d_pops", it), pops, n);
            chk($sformatf("r%0d_depth", it), depth, (d > n) ? d - n : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo_drain_reader.md
LIFO_DRAIN_READER -- requirements
Module: lifo_drain_reader

Interface
REQ-001 SHALL have parameter LIFO_SIZE, default 8, depth of the attached LIFO in entries.
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have lifo_val  input  1  LIFO not empty.
REQ-006 SHALL have lifo_full  input  1  LIFO full; status only.
REQ-007 SHALL have lifo_data  input  DATA_W  combinational top-of-stack word from the LIFO.
REQ-008 SHALL have lifo_read  output  1  pop strobe to the LIFO, one entry per asserted cycle.
REQ-009 SHALL have start  input  1  single-cycle request to begin a drain burst.
REQ-010 SHALL have len  input  CNT_W = clog2(LIFO_SIZE)+1  burst length, sampled with start.
REQ-011 SHALL have m_valid  output  1, m_data  output  DATA_W, m_last  output  1, m_ready  input  1  output stream.
REQ-012 SHALL have busy  output  1  high while not IDLE.
REQ-013 SHALL have done  output  1  one-cycle pulse at burst completion.
REQ-014 SHALL have remaining  output  CNT_W  words not yet popped in the current burst.

Function
REQ-015 SHALL implement an FSM with states IDLE, DRAIN and FLUSH.
REQ-016 IDLE->DRAIN on start=1 with len!=0; len is loaded into remaining, clamped to LIFO_SIZE when len>LIFO_SIZE.
REQ-017 start with len=0 SHALL be ignored: no state change, no done pulse.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 In DRAIN, a pop SHALL occur when lifo_val=1 and remaining!=0 and (m_valid=0 or m_ready=1).
REQ-020 A pop SHALL assert lifo_read for that cycle, load lifo_data into m_data at the same edge, set m_valid=1 and decrement remaining.
REQ-021 Pop-to-output latency SHALL be one cycle; sustained throughput SHALL be one word per cycle while m_ready=1 and lifo_val=1.
REQ-022 lifo_read SHALL never be asserted while lifo_val=0 or outside DRAIN.
REQ-023 m_last SHALL be set together with m_data when the popped word brings remaining to 0; the FSM then goes to FLUSH.
REQ-024 In DRAIN with lifo_val=0, the FSM SHALL stall and hold remaining, m_valid and m_data; there is no timeout.
REQ-025 m_valid, m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-026 A handshake (m_valid&m_ready) with no simultaneous pop SHALL clear m_valid and m_last.
REQ-027 In FLUSH, a handshake on the last word SHALL pulse done for one cycle and return the FSM to IDLE.
REQ-028 A start in the same cycle as done SHALL be ignored.
REQ-029 Words SHALL emerge in pop order, i.e. most recent push first.
REQ-030 remaining SHALL never underflow below 0.

Reset
REQ-031 Asserting reset, including mid-burst, SHALL force IDLE and set lifo_read=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, remaining=0.
REQ-032 After reset deasserts, the block SHALL wait for a new start and SHALL NOT resume the aborted burst.

Structure
REQ-033 Package lifo_pkg SHALL hold the FSM state encoding constants and the CNT_W width function.
REQ-034 The output register (m_valid, m_data, m_last with load/accept) SHALL be a sub-module stream_out_reg.
REQ-035 The FSM, counter and pop logic SHALL reside in lifo_drain_reader.

Verification
REQ-036 Basic drain: push 0x11,0x22,0x33 into an attached LIFO (8x8); start, len=3; m_ready=1 -> m_data 0x33,0x22,0x11 on consecutive cycles; m_last on 0x11; done one cycle after the 0x11 handshake.
REQ-037 Backpressure: same data, m_ready low for 4 cycles after the first word -> 0x33 held stable; lifo_read=0 during the stall; order intact; exactly 3 pops.
REQ-038 Underflow stall: LIFO holds 2 words, len=4 -> 2 words out, stall with remaining=2; push 0xA5 -> 0xA5 emitted, remaining=1; push 0x5A -> 0x5A emitted with m_last, then done.
REQ-039 Clamp and ignore: len=12 on a full LIFO -> exactly 8 pops, m_last on the 8th word; len=0 -> busy stays 0, no done; start while busy -> no effect.
REQ-040 Reset mid-burst: assert reset after 2 of 5 pops -> all outputs 0 immediately (asynchronously); after release, 3 words remain in the LIFO and no lifo_read occurs until the next start.
